// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the KxK convolution core: clears the core, loads the kernel, streams one frame,
// and re-times the core outputs that belong to fully-interior windows into a valid-qualified stream.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for start; core untouched
// CLEAR       | one cycle of core_reset before a kernel reload
// LOAD_KERNEL | accepting K*K coefficients, gaps allowed
// STREAM      | one pixel slot per clock into the core line buffer
// DRAIN       | PIPE_LAT cycles for the last windows to leave the core
module conv_frame_ctrl #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int PIPE_LAT    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            reload_kernel,
    input  logic            abort,
    input  logic            kernel_in_valid,
    input  logic [BITS-1:0] kernel_in,
    output logic            kernel_ready,
    input  logic            pixel_in_valid,
    input  logic [BITS-1:0] pixel_in,
    output logic            pixel_ready,
    output logic            core_reset,
    output logic            core_kernel_write_en,
    output logic [BITS-1:0] core_kernel_in,
    output logic            core_shift_write_en,
    output logic [BITS-1:0] core_img_in,
    input  logic [BITS-1:0] core_pixel_out,
    output logic [BITS-1:0] pixel_out,
    output logic            pixel_out_valid,
    output logic            busy,
    output logic            done,
    output logic            underrun
);

    localparam int NK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KW = $clog2(NK + 1);
    localparam int CW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST     = KW'(NK - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_LENGTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST  = RW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_KERNEL,
        STREAM,
        DRAIN
    } state_t;

    state_t                state;
    logic [KW-1:0]         kcount;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DW-1:0]         dcount;
    logic [PIPE_LAT-1:0]   tag_pipe;
    logic                  tag_in;

    assign busy                 = (state != IDLE);
    assign kernel_ready         = (state == LOAD_KERNEL);
    assign pixel_ready          = (state == STREAM);
    assign core_shift_write_en  = pixel_ready;
    assign core_kernel_write_en = kernel_ready && kernel_in_valid;
    assign core_kernel_in       = kernel_in;
    assign core_img_in          = (pixel_ready && pixel_in_valid) ? pixel_in : '0;
    assign core_reset           = reset || (state == CLEAR);

    // Only windows lying wholly inside the frame are tagged; column wrap-around windows never are.
    assign tag_in = (state == STREAM) && (row >= ROW_FIRST) && (col >= COL_FIRST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            kcount          <= '0;
            col             <= '0;
            row             <= '0;
            dcount          <= '0;
            tag_pipe        <= '0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            done            <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (tag_pipe[PIPE_LAT-1]) begin
                pixel_out       <= core_pixel_out;
                pixel_out_valid <= 1'b1;
            end else begin
                pixel_out_valid <= 1'b0;
            end

            tag_pipe[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (abort && (state != IDLE)) begin
                state           <= IDLE;
                kcount          <= '0;
                col             <= '0;
                row             <= '0;
                dcount          <= '0;
                tag_pipe        <= '0;
                pixel_out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            underrun <= 1'b0;
                            state    <= reload_kernel ? CLEAR : STREAM;
                        end
                    end
                    CLEAR: begin
                        state <= LOAD_KERNEL;
                    end
                    LOAD_KERNEL: begin
                        if (kernel_in_valid) begin
                            if (kcount == K_LAST) begin
                                kcount <= '0;
                                state  <= STREAM;
                            end else begin
                                kcount <= kcount + 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        // A missing pixel still consumes its slot: the core shifts regardless.
                        if (!pixel_in_valid) begin
                            underrun <= 1'b1;
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (dcount == DRAIN_LAST) begin
                            dcount <= '0;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            dcount <= dcount + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 convolution core. It clears the core, loads the K*K kernel, and streams one IMG_LENGTH x IMG_HEIGHT frame into the core's line-buffer shift register. It tags which core outputs belong to fully-interior windows and re-times them into a clean valid-qualified pixel stream. It also reports frame completion. It sits between the host-side pixel/kernel sources (GPIO or LA) and the convolve core.

Parameters:
BITS, 9, pixel and kernel coefficient width
KERNEL_SIZE, 3, kernel edge K
IMG_LENGTH, 16, frame width W in pixels; must match the core
IMG_HEIGHT, 16, frame height H in pixels
PIPE_LAT, 2, cycles from the core shift_write_en edge carrying pixel n to core_pixel_out holding the window ending at n

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin frame; sampled only in IDLE
reload_kernel  input  1  sampled with start; 1 = clear core and load new kernel
abort  input  1  return to IDLE next cycle, no done
kernel_in_valid  input  1  kernel coefficient present
kernel_in  input  BITS  kernel coefficient, row-major
kernel_ready  output  1  high in LOAD_KERNEL
pixel_in_valid  input  1  pixel present
pixel_in  input  BITS  pixel, raster order
pixel_ready  output  1  high in STREAM
core_reset  output  1  reset to convolve core
core_kernel_write_en  output  1  to core kernel_write_en
core_kernel_in  output  BITS  to core kernel_in
core_shift_write_en  output  1  to core shift_write_en
core_img_in  output  BITS  to core img_input
core_pixel_out  input  BITS  from core img_output
pixel_out  output  BITS  registered filtered pixel
pixel_out_valid  output  1  pixel_out holds a valid interior-window result
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of frame
underrun  output  1  sticky; a STREAM cycle occurred without pixel_in_valid

Behaviour:
- States: IDLE, CLEAR, LOAD_KERNEL, STREAM, DRAIN.
- Reset values: state IDLE; all counters 0; pixel_out 0; pixel_out_valid, done, busy, underrun, kernel_ready, pixel_ready and all core_*_en 0. core_reset is 1 while reset is high.
- core_reset = reset OR (state == CLEAR).
- IDLE: on start with reload_kernel=1, go to CLEAR. On start with reload_kernel=0, go to STREAM; the kernel is retained in the core. Clear underrun on start.
- CLEAR: exactly 1 cycle, then LOAD_KERNEL.
- LOAD_KERNEL: kernel_ready=1. Each cycle with kernel_in_valid: core_kernel_write_en=1, core_kernel_in=kernel_in (combinational pass-through), kcount+1. Gaps are allowed. When the K*K-th coefficient is accepted, go to STREAM next cycle.
- STREAM: pixel_ready=1 and core_shift_write_en=1 every cycle. The core shifts every clock, so the feed is gapless by contract.
  - If pixel_in_valid=0: core_img_in=0, set underrun, and still count the slot as a pixel.
  - Pixel counter n: col 0..W-1, row 0..H-1; col wraps to 0 and row increments.
  - Window tag for slot n = (row >= K-1) AND (col >= K-1).
  - After slot W*H-1, go to DRAIN.
- Tag pipeline: PIPE_LAT-deep shift register of tags, advancing every cycle (0 is shifted in outside STREAM). When the tag emerges: pixel_out <= core_pixel_out and pixel_out_valid <= 1; otherwise pixel_out_valid <= 0 and pixel_out holds its value.
- DRAIN: wait PIPE_LAT cycles, then done=1 for one cycle and go to IDLE. Total valid outputs per frame = (H-K+1)*(W-K+1) = 196 at defaults.
- Column wrap-around windows (col < K-1) are never tagged valid, even though the core produces values for them.
- abort (any non-IDLE state): go to IDLE next cycle; flush the tag pipeline; no done; counters cleared. abort in IDLE is ignored.
- start while busy is ignored. abort takes priority over every transition. reset takes priority over abort.
- Reset mid-frame: immediate return to reset values. The core is cleared via core_reset.

Test Plan:
- Reset, then start+reload_kernel with kernel 0,0,0,0,1,0,0,0,0 and a 16x16 ramp p=n mod 256 -> core_reset pulses 1 cycle; 196 valid outputs, each equal to the pixel at (row-1, col-1), in raster order; done pulses once, PIPE_LAT cycles after the last pixel.
- Kernel delivered with 2-cycle gaps between coefficients -> exactly 9 core_kernel_write_en pulses; STREAM entered only after the 9th coefficient.
- Second frame with reload_kernel=0 -> no core_reset pulse and no kernel writes; 196 outputs using the retained kernel.
- pixel_in_valid dropped for 1 cycle at n=100 -> underrun=1 and stays set; frame still ends after 256 slots; underrun cleared by the next start.
- abort during STREAM at n=50 -> IDLE next cycle; pixel_out_valid=0 thereafter; no done; a new start runs a full frame correctly.
- reset asserted in LOAD_KERNEL after 4 coefficients -> all outputs at reset values the next cycle; busy=0; core_reset=1 while reset is held.
